ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the same PS2_CLK/PS2_DATA pins the ps2 receiver listens on.
- Drives both lines open-drain: an output-enable of 1 pulls the line low; 0 releases it.
- Reports success, device NACK or timeout.
- busy is used by top-level glue to gate the receiver during a transmission.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles the clock line is held low before the request (100 us at 50 MHz).
- START_CYCLES, 50: clk cycles data is held low with clock still low, before the clock is released.
- TIMEOUT_CYCLES, 750000: maximum clk cycles from clock release to ACK sampled (15 ms at 50 MHz).
- MAX_RETRIES, 2: extra attempts after a failure (used only with PS2_TX_RETRY_EN).

Ports:
- clk  in  1  system clock (CLK50MHZ domain)
- rst  in  1  synchronous reset, active-high
- tx_data  in  8  byte to send
- tx_valid  in  1  request; accepted when tx_valid & tx_ready
- tx_ready  out  1  high only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: byte sent and ACKed
- err  out  1  one-cycle pulse: transfer failed
- err_code  out  2  01 NACK, 10 timeout; held until the next accept
- ps2_clk_in  in  1  raw PS2_CLK pin level
- ps2_data_in  in  1  raw PS2_DATA pin level
- ps2_clk_oe  out  1  1 = pull PS2_CLK low
- ps2_data_oe  out  1  1 = pull PS2_DATA low

Behaviour:
- Reset: all outputs 0, state IDLE. tx_ready goes 1 in the first cycle after rst falls.
- Input sync: both pin inputs pass through a 2-FF synchronizer. fall = prev_sync & ~sync. Pin edge to fall detect = 3 cycles.
- On accept: latch tx_data, parity = ~^tx_data (odd parity), edge_cnt = 0, clear err_code. tx_valid while busy is ignored; no queueing.
- IDLE: both oe = 0, tx_ready = 1.
- INHIBIT: clk_oe = 1, data_oe = 0 for exactly INHIBIT_CYCLES cycles, then REQ.
- REQ: clk_oe = 1, data_oe = 1 (start bit) for START_CYCLES cycles, then SEND.
- SEND: clk_oe = 0. Timeout counter starts at 0. data_oe stays 1 until the first fall.
  - Each fall increments edge_cnt (4-bit).
  - edge 1..8: data_oe = ~tx_data[edge-1] (LSB first).
  - edge 9: data_oe = ~parity.
  - edge 10: data_oe = 0 (stop bit, released).
  - edge 11: sample data_sync. 0 = ACK, go WAIT_IDLE with result OK. 1 = NACK, go WAIT_IDLE with result NACK.
- WAIT_IDLE: both oe = 0. Wait until clk_sync & data_sync are both 1, then enter IDLE and pulse done (OK) or err with err_code = 01 (NACK).
- Timeout: the counter runs through SEND and WAIT_IDLE. When it reaches TIMEOUT_CYCLES in either state:
  - release both lines in the same cycle;
  - pulse err, err_code = 10;
  - go to IDLE.
- done and err are never high together. Exactly one of them pulses per accepted byte unless reset intervenes.
- rst mid-transfer: both oe = 0 at the next edge, state IDLE, no done/err pulse, err_code = 00.
- A fall outside SEND is ignored.

Optional Feature:
- Macro PS2_TX_RETRY_EN.
- Defined: on NACK (after WAIT_IDLE completes) or on timeout, if retry_cnt < MAX_RETRIES:
  - increment retry_cnt;
  - re-enter INHIBIT with the same byte;
  - no err pulse.
  - err/err_code is reported only after the final failed attempt. retry_cnt clears on accept.
- Not defined: single attempt; every failure reports immediately. No retry logic is present.

Test Plan:
- Bench parameters INHIBIT_CYCLES = 20, START_CYCLES = 4, TIMEOUT_CYCLES = 4000. A device model clocks at 100-cycle half-periods, samples data on rising edges and drives ACK low on clock 11.
- Send 0xED: device samples start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1. Response: done pulses once, err = 0, tx_ready = 1.
- Inhibit/request timing: clk_oe high exactly 24 cycles after accept. data_oe rises exactly 20 cycles after accept.
- Send 0x00 with the model holding data high on clock 11: parity 1, err pulse, err_code = 01, no done.
- Device never clocks: err pulse 4000 cycles after clock release, err_code = 10, both oe = 0 in that cycle.
- rst asserted after edge 4 of 0xFF: both oe = 0 the next cycle, no done/err. A following send of 0xF4 completes with done.
- tx_valid held during a transfer: only one byte is sent. With PS2_TX_RETRY_EN and a NACK-always device: 3 attempts, then a single err with err_code = 01.

Source files
------------

// File: rtl/ps2_host_tx_if.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_if
//   Command-side bus of the PS/2 host transmitter.
//   master : the requester (drives tx_data/tx_valid, watches status)
//   slave  : the transmitter (ps2_host_tx)
//   Signals:
//     tx_data  [7:0] byte to send
//     tx_valid       request, taken when tx_valid & tx_ready
//     tx_ready       transmitter idle and able to accept
//     busy           transfer in progress (used to gate the PS/2 receiver)
//     done           one-cycle pulse, byte sent and ACKed
//     err            one-cycle pulse, transfer failed
//     err_code [1:0] 01 NACK, 10 timeout; held until the next accept
// ---------------------------------------------------------------------------
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, err, err_code
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, err, err_code
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//   PS/2 host-to-device transmitter. Inhibits the bus, issues a request-to-
//   send, then shifts one byte (LSB first, odd parity, stop) out on the
//   falling edges of the device-generated clock and samples the device ACK.
//   Both PS/2 lines are driven open-drain through output enables.
//
//   Optional build macro: PS2_TX_RETRY_EN
//     When defined, a NACK or timeout re-runs the whole transfer with the
//     same byte up to MAX_RETRIES extra times before err is reported.
//
//   Ports:
//     clk          system clock
//     rst          synchronous reset, active-high
//     host         ps2_host_tx_if.slave command/status bus
//     ps2_clk_in   raw PS2_CLK pin level
//     ps2_data_in  raw PS2_DATA pin level
//     ps2_clk_oe   1 = pull PS2_CLK low
//     ps2_data_oe  1 = pull PS2_DATA low
// ---------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int MAX_RETRIES    = 2
) (
  input  logic               clk,
  input  logic               rst,
  ps2_host_tx_if.slave       host,
  input  logic               ps2_clk_in,
  input  logic               ps2_data_in,
  output logic               ps2_clk_oe,
  output logic               ps2_data_oe
);

  localparam int PHASE_MAX = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
  localparam int PW        = $clog2(PHASE_MAX + 1);
  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd2;
  localparam logic [2:0] ST_SEND      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  localparam logic [1:0] CODE_NACK    = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;

  // ---------------------------------------------------------------------
  // Pin synchronizers. Reset to 1 so an idle bus never looks like a fall.
  // ---------------------------------------------------------------------
  logic clk_meta_reg, clk_sync_reg, clk_prev_reg;
  logic data_meta_reg, data_sync_reg;
  logic clk_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_reg  <= 1'b1;
      clk_sync_reg  <= 1'b1;
      clk_prev_reg  <= 1'b1;
      data_meta_reg <= 1'b1;
      data_sync_reg <= 1'b1;
    end else begin
      clk_meta_reg  <= ps2_clk_in;
      clk_sync_reg  <= clk_meta_reg;
      clk_prev_reg  <= clk_sync_reg;
      data_meta_reg <= ps2_data_in;
      data_sync_reg <= data_meta_reg;
    end
  end

  assign clk_fall = clk_prev_reg & ~clk_sync_reg;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [2:0]    state_reg,     state_next;
  logic [PW-1:0] phase_cnt_reg, phase_cnt_next;
  logic [TW-1:0] tmo_cnt_reg,   tmo_cnt_next;
  logic [3:0]    edge_cnt_reg,  edge_cnt_next;
  logic [7:0]    data_reg,      data_next;
  logic          parity_reg,    parity_next;
  logic          data_oe_reg,   data_oe_next;
  logic          nack_reg,      nack_next;
  logic          done_reg,      done_next;
  logic          err_reg,       err_next;
  logic [1:0]    err_code_reg,  err_code_next;
  // Holds tx_ready low through reset and releases it one cycle later.
  logic          run_reg;

`ifdef PS2_TX_RETRY_EN
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  logic [RW-1:0] retry_cnt_reg, retry_cnt_next;
`endif

  logic       tx_ready_w;
  logic       accept;
  logic       fail;
  logic [1:0] fail_code;
  logic [3:0] edge_inc;

  assign tx_ready_w = (state_reg == ST_IDLE) & run_reg;
  assign accept     = host.tx_valid & tx_ready_w;

  always_comb begin
    state_next     = state_reg;
    phase_cnt_next = phase_cnt_reg;
    tmo_cnt_next   = tmo_cnt_reg;
    edge_cnt_next  = edge_cnt_reg;
    data_next      = data_reg;
    parity_next    = parity_reg;
    data_oe_next   = data_oe_reg;
    nack_next      = nack_reg;
    err_code_next  = err_code_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;
    fail           = 1'b0;
    fail_code      = 2'b00;
    edge_inc       = edge_cnt_reg + 4'd1;
`ifdef PS2_TX_RETRY_EN
    retry_cnt_next = retry_cnt_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        data_oe_next = 1'b0;
        if (accept) begin
          data_next      = host.tx_data;
          parity_next    = ~^host.tx_data;
          edge_cnt_next  = 4'd0;
          err_code_next  = 2'b00;
          phase_cnt_next = '0;
          state_next     = ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_cnt_next = '0;
`endif
        end
      end

      ST_INHIBIT: begin
        if (phase_cnt_reg == PW'(INHIBIT_CYCLES - 1)) begin
          phase_cnt_next = '0;
          state_next     = ST_REQ;
        end else begin
          phase_cnt_next = phase_cnt_reg + 1'b1;
        end
      end

      ST_REQ: begin
        if (phase_cnt_reg == PW'(START_CYCLES - 1)) begin
          phase_cnt_next = '0;
          tmo_cnt_next   = '0;
          edge_cnt_next  = 4'd0;
          data_oe_next   = 1'b1;  // start bit keeps data low after clock release
          state_next     = ST_SEND;
        end else begin
          phase_cnt_next = phase_cnt_reg + 1'b1;
        end
      end

      ST_SEND: begin
        tmo_cnt_next = tmo_cnt_reg + 1'b1;
        if (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
          fail      = 1'b1;
          fail_code = CODE_TIMEOUT;
        end else if (clk_fall) begin
          edge_cnt_next = edge_inc;
          if (edge_inc <= 4'd8) begin
            data_oe_next = ~data_reg[3'(edge_inc - 4'd1)];
          end else if (edge_inc == 4'd9) begin
            data_oe_next = ~parity_reg;
          end else if (edge_inc == 4'd10) begin
            data_oe_next = 1'b0;
          end else begin
            // 11th fall: device holds data low to ACK.
            data_oe_next = 1'b0;
            nack_next    = data_sync_reg;
            state_next   = ST_WAIT_IDLE;
          end
        end
      end

      ST_WAIT_IDLE: begin
        data_oe_next = 1'b0;
        tmo_cnt_next = tmo_cnt_reg + 1'b1;
        if (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
          fail      = 1'b1;
          fail_code = CODE_TIMEOUT;
        end else if (clk_sync_reg & data_sync_reg) begin
          if (nack_reg) begin
            fail      = 1'b1;
            fail_code = CODE_NACK;
          end else begin
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end

      default: begin
        data_oe_next = 1'b0;
        state_next   = ST_IDLE;
      end
    endcase

    if (fail) begin
`ifdef PS2_TX_RETRY_EN
      if (retry_cnt_reg < RW'(MAX_RETRIES)) begin
        retry_cnt_next = retry_cnt_reg + 1'b1;
        phase_cnt_next = '0;
        edge_cnt_next  = 4'd0;
        data_oe_next   = 1'b0;
        state_next     = ST_INHIBIT;
      end else begin
        data_oe_next   = 1'b0;
        err_next       = 1'b1;
        err_code_next  = fail_code;
        state_next     = ST_IDLE;
      end
`else
      data_oe_next  = 1'b0;
      err_next      = 1'b1;
      err_code_next = fail_code;
      state_next    = ST_IDLE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      phase_cnt_reg <= '0;
      tmo_cnt_reg   <= '0;
      edge_cnt_reg  <= 4'd0;
      data_reg      <= 8'd0;
      parity_reg    <= 1'b0;
      data_oe_reg   <= 1'b0;
      nack_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      err_code_reg  <= 2'b00;
      run_reg       <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_cnt_reg <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      phase_cnt_reg <= phase_cnt_next;
      tmo_cnt_reg   <= tmo_cnt_next;
      edge_cnt_reg  <= edge_cnt_next;
      data_reg      <= data_next;
      parity_reg    <= parity_next;
      data_oe_reg   <= data_oe_next;
      nack_reg      <= nack_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      err_code_reg  <= err_code_next;
      run_reg       <= 1'b1;
`ifdef PS2_TX_RETRY_EN
      retry_cnt_reg <= retry_cnt_next;
`endif
    end
  end

  // Line drivers derive from state, so a state change releases the lines
  // in the same cycle (timeout, reset).
  assign ps2_clk_oe  = (state_reg == ST_INHIBIT) | (state_reg == ST_REQ);
  assign ps2_data_oe = (state_reg == ST_REQ) | ((state_reg == ST_SEND) & data_oe_reg);

  assign host.tx_ready = tx_ready_w;
  assign host.busy     = (state_reg != ST_IDLE);
  assign host.done     = done_reg;
  assign host.err      = err_reg;
  assign host.err_code = err_code_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
//   Directed bench for ps2_host_tx with a behavioural PS/2 device model
//   (100-cycle clock half-periods, samples data on rising clock, ACK on
//   clock 11). Expected frames are hand-computed constants:
//     frame[0] start, frame[8:1] data LSB first, frame[9] parity, frame[10] stop
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int STA = 4;
  localparam int TMO = 4000;
`ifdef PS2_TX_RETRY_EN
  localparam int N_ATT = 3;
`else
  localparam int N_ATT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;

  ps2_host_tx_if bus();

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_CYCLES   (STA),
    .TIMEOUT_CYCLES (TMO),
    .MAX_RETRIES    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .host        (bus),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  // Wired-AND open-drain bus with pull-ups.
  assign ps2_clk_in  = ~(ps2_clk_oe  | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: event counts and timestamps sampled on the falling edge.
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int t_clk_rise = 0, t_clk_fall = 0, t_data_rise = 0, t_err = 0;
  logic [1:0] code_at_err = 2'b00;
  logic [1:0] oe_at_err   = 2'b00;
  logic prev_clk_oe = 1'b0, prev_data_oe = 1'b0, armed = 1'b0;

  always @(negedge clk) begin
    if (ps2_clk_oe && !prev_clk_oe) begin
      t_clk_rise = cyc;
      armed      = 1'b1;
    end
    if (!ps2_clk_oe && prev_clk_oe) t_clk_fall = cyc;
    if (ps2_data_oe && !prev_data_oe && armed) begin
      t_data_rise = cyc;
      armed       = 1'b0;
    end
    if (bus.done) done_cnt++;
    if (bus.err) begin
      err_cnt++;
      t_err       = cyc;
      code_at_err = bus.err_code;
      oe_at_err   = {ps2_clk_oe, ps2_data_oe};
    end
    if (bus.done && bus.err) both_cnt++;
    prev_clk_oe  = ps2_clk_oe;
    prev_data_oe = ps2_data_oe;
  end

  // Device: wait for request-to-send, then generate nclk clocks.
  task automatic dev_run(input logic ack, input int nclk,
                         output logic [10:0] frame, output logic ok);
    int w;
    frame = '0;
    ok    = 1'b0;
    w     = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w < 2000) begin
      ok = 1'b1;
      repeat (10) @(negedge clk);
      frame[0] = ps2_data_in;
      for (int i = 1; i <= nclk; i++) begin
        if (i == 11) dev_data_low = ack;
        dev_clk_low = 1'b1;
        repeat (100) @(negedge clk);
        dev_clk_low = 1'b0;
        if (i <= 10) frame[i] = ps2_data_in;
        repeat (100) @(negedge clk);
      end
      dev_data_low = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int base, input int budget);
    int w;
    w = 0;
    while ((done_cnt + err_cnt) == base && w < budget) begin
      @(negedge clk);
      w++;
    end
    if (w >= budget) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_wait got=timeout exp=result", tag);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] frame;
    logic        ok;
    int          bd, be, w;

    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;

    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_ready",  bus.tx_ready, 0);
    chk("rst_busy",   bus.busy, 0);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_dat_oe", ps2_data_oe, 0);
    chk("rst_done",   bus.done, 0);
    chk("rst_err",    bus.err, 0);
    chk("rst_code",   bus.err_code, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", bus.tx_ready, 1);

    // 0xED with ACK, plus inhibit/request timing
    bd = done_cnt; be = err_cnt;
    send(8'hED);
    dev_run(1'b1, 11, frame, ok);
    chk("ed_dev_ok", ok, 1);
    chk("ed_frame", frame, 11'h7DA);
    wait_result("ed", bd + be, 1000);
    chk("ed_done",  done_cnt - bd, 1);
    chk("ed_err",   err_cnt - be, 0);
    chk("ed_ready", bus.tx_ready, 1);
    chk("inh_clk_oe_len",   t_clk_fall - t_clk_rise, INH + STA);
    chk("inh_data_rise",    t_data_rise - t_clk_rise, INH);
    $display("TX ED frame=%03h done=%0d err=%0d", frame, done_cnt - bd, err_cnt - be);

    // 0x00 with NACK on every attempt
    bd = done_cnt; be = err_cnt;
    send(8'h00);
    for (int a = 0; a < N_ATT; a++) begin
      dev_run(1'b0, 11, frame, ok);
      chk("nack_dev_ok", ok, 1);
      chk("nack_frame", frame, 11'h600);
    end
    wait_result("nack", bd + be, 1000);
    chk("nack_err",  err_cnt - be, 1);
    chk("nack_done", done_cnt - bd, 0);
    chk("nack_code", code_at_err, 2'b01);
    dev_run(1'b0, 11, frame, ok);
    chk("nack_no_extra_attempt", ok, 0);
    $display("TX 00 attempts=%0d err=%0d code=%0d", N_ATT, err_cnt - be, code_at_err);

    // Device never clocks
    bd = done_cnt; be = err_cnt;
    send(8'h5A);
    wait_result("tmo", bd + be, N_ATT * (TMO + 200) + 200);
    chk("tmo_err",   err_cnt - be, 1);
    chk("tmo_done",  done_cnt - bd, 0);
    chk("tmo_code",  code_at_err, 2'b10);
    chk("tmo_delay", t_err - t_clk_fall, TMO);
    chk("tmo_oe",    oe_at_err, 2'b00);
    $display("TX 5A timeout err=%0d code=%0d delay=%0d", err_cnt - be, code_at_err, t_err - t_clk_fall);

    // Reset after the 4th falling edge of 0xFF
    bd = done_cnt; be = err_cnt;
    send(8'hFF);
    dev_run(1'b1, 4, frame, ok);
    chk("rstmid_dev_ok", ok, 1);
    chk("rstmid_partial", frame[4:0], 5'h1E);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_clk_oe", ps2_clk_oe, 0);
    chk("rstmid_dat_oe", ps2_data_oe, 0);
    chk("rstmid_busy",   bus.busy, 0);
    chk("rstmid_code",   bus.err_code, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rstmid_no_done", done_cnt - bd, 0);
    chk("rstmid_no_err",  err_cnt - be, 0);
    chk("rstmid_ready",   bus.tx_ready, 1);
    $display("TX FF aborted by reset");

    // 0xF4 after the aborted transfer
    bd = done_cnt; be = err_cnt;
    send(8'hF4);
    dev_run(1'b1, 11, frame, ok);
    chk("f4_frame", frame, 11'h5E8);
    wait_result("f4", bd + be, 1000);
    chk("f4_done", done_cnt - bd, 1);
    chk("f4_err",  err_cnt - be, 0);
    $display("TX F4 frame=%03h done=%0d", frame, done_cnt - bd);

    // tx_valid held for the whole transfer
    bd = done_cnt; be = err_cnt;
    @(negedge clk);
    bus.tx_data  = 8'h3C;
    bus.tx_valid = 1'b1;
    dev_run(1'b1, 11, frame, ok);
    chk("held_frame", frame, 11'h678);
    w = 0;
    while (!bus.done && w < 1000) begin
      @(negedge clk);
      w++;
    end
    bus.tx_valid = 1'b0;
    chk("held_done_seen", (w < 1000), 1);
    dev_run(1'b1, 11, frame, ok);
    chk("held_no_second", ok, 0);
    chk("held_done_cnt", done_cnt - bd, 1);
    chk("held_busy", bus.busy, 0);
    $display("TX 3C held-valid done=%0d", done_cnt - bd);

    chk("done_err_exclusive", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
